// File: rtl/cpu_pkg.sv
// Shared MU0 definitions: sequencer states, opcode constants and field widths.
// The PAUSE state exists only when CPU_SEQ_STEP_EN is defined.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned ADDR_W  = 12;

  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_STA = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_JMP = 4'h4;
  localparam logic [OP_W-1:0] OP_JMI = 4'h5;
  localparam logic [OP_W-1:0] OP_JEQ = 4'h6;
  localparam logic [OP_W-1:0] OP_STP = 4'h7;
  localparam logic [OP_W-1:0] OP_LDI = 4'h8;
  localparam logic [OP_W-1:0] OP_LSL = 4'h9;
  localparam logic [OP_W-1:0] OP_LRL = 4'hA;

`ifdef CPU_SEQ_STEP_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
    S_HALT  = 3'd4,
    S_PAUSE = 3'd5
  } seq_state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
    S_HALT  = 3'd4
  } seq_state_e;
`endif

endpackage

// File: rtl/cpu_sequencer.sv
// MU0 control-state sequencer: phase generation, instruction register and retire counter.
// Optional single-step support (STEP_MODE/STEP/PAUSED ports) under CPU_SEQ_STEP_EN.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] IR_RESET = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] MEM_DATA,
  input  logic        MEM_READY,
  input  logic        RUN,
`ifdef CPU_SEQ_STEP_EN
  input  logic        STEP_MODE,
  input  logic        STEP,
  output logic        PAUSED,
`endif
  output logic        FETCH,
  output logic        EXEC1,
  output logic        EXEC2,
  output logic [3:0]  OP,
  output logic [11:0] OPERAND,
  output logic        HALTED,
  output logic [15:0] INSTR_COUNT
);

  seq_state_e         state_q, state_d;
  seq_state_e         retire_tgt;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [15:0]        instr_count_q, instr_count_d;
  logic               fetch_q, fetch_d;
  logic               exec1_q, exec1_d;
  logic               exec2_q, exec2_d;
  logic               halted_q, halted_d;
  logic               retire;
`ifdef CPU_SEQ_STEP_EN
  logic               paused_q, paused_d;
`endif

  // Next state, IR load, retirement and registered output decode.
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    retire        = 1'b0;
`ifdef CPU_SEQ_STEP_EN
    retire_tgt    = STEP_MODE ? S_PAUSE : S_FETCH;
`else
    retire_tgt    = S_FETCH;
`endif

    case (state_q)
      S_IDLE, S_HALT: begin
        if (RUN) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (MEM_READY) begin
          ir_d    = MEM_DATA;
          state_d = S_EXEC1;
        end
      end
      S_EXEC1: begin
        case (ir_q[INSTR_W-1 -: OP_W])
          OP_LDA: begin
            if (MEM_READY) state_d = S_EXEC2;
          end
          OP_STA, OP_ADD, OP_SUB: begin
            if (MEM_READY) begin
              retire  = 1'b1;
              state_d = retire_tgt;
            end
          end
          OP_STP: begin
            retire  = 1'b1;
            state_d = S_HALT;
          end
          OP_JMP, OP_JMI, OP_JEQ, OP_LDI, OP_LSL, OP_LRL: begin
            retire  = 1'b1;
            state_d = retire_tgt;
          end
          // Undefined opcodes retire as NOPs.
          default: begin
            retire  = 1'b1;
            state_d = retire_tgt;
          end
        endcase
      end
      S_EXEC2: begin
        retire  = 1'b1;
        state_d = retire_tgt;
      end
`ifdef CPU_SEQ_STEP_EN
      S_PAUSE: begin
        if (STEP) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    instr_count_d = retire ? instr_count_q + 16'd1 : instr_count_q;

    fetch_d  = (state_d == S_FETCH);
    exec1_d  = (state_d == S_EXEC1);
    exec2_d  = (state_d == S_EXEC2);
    halted_d = (state_d == S_IDLE) || (state_d == S_HALT);
`ifdef CPU_SEQ_STEP_EN
    paused_d = (state_d == S_PAUSE);
`endif
  end

  // State, IR, counter and output flops.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= S_IDLE;
      ir_q          <= IR_RESET;
      instr_count_q <= 16'h0000;
      fetch_q       <= 1'b0;
      exec1_q       <= 1'b0;
      exec2_q       <= 1'b0;
      halted_q      <= 1'b1;
`ifdef CPU_SEQ_STEP_EN
      paused_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      instr_count_q <= instr_count_d;
      fetch_q       <= fetch_d;
      exec1_q       <= exec1_d;
      exec2_q       <= exec2_d;
      halted_q      <= halted_d;
`ifdef CPU_SEQ_STEP_EN
      paused_q      <= paused_d;
`endif
    end
  end

  assign FETCH       = fetch_q;
  assign EXEC1       = exec1_q;
  assign EXEC2       = exec2_q;
  assign HALTED      = halted_q;
  assign OP          = ir_q[INSTR_W-1 -: OP_W];
  assign OPERAND     = ir_q[ADDR_W-1:0];
  assign INSTR_COUNT = instr_count_q;
`ifdef CPU_SEQ_STEP_EN
  assign PAUSED      = paused_q;
`endif

endmodule
